// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer for a 3-stage core: load-use bubbles, redirect flushes, dmem freeze.
// Latency: all control outputs are combinational from the registered state and the current inputs.
// Backpressure: dmem_busy freezes PC, IF/ID and X/WB; it takes priority over redirects and load-use stalls.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rf_wen_X,
  input  logic        ld_X,
  input  logic [4:0]  rd_X,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        rs1_used_ID,
  input  logic        rs2_used_ID,
  input  logic        redirect_X,
  input  logic        dmem_busy,
  input  logic        clr_cnt,
  output logic        stall_PC,
  output logic        stall_ID,
  output logic        stall_X,
  output logic        bubble_X,
  output logic        flush_ID,
  output logic        timeout_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] FC_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] MT_LIMIT  = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic ld_use;
  logic run_eval;
  logic freeze;
  logic flush;
  logic ld_stall;

  // Load-use hazard that the WB forwarding path cannot cover this cycle.
  always_comb begin
    ld_use = ld_X & rf_wen_X & (rd_X != 5'd0) &
             ((rs1_used_ID & (rs1_ID == rd_X)) | (rs2_used_ID & (rs2_ID == rd_X)));
  end

  // Next-state and control decode; MEM_WAIT exit reuses the RUN decision so redirect/ld_use add no latency.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    wait_cnt_d = wait_cnt_q;
    run_eval   = 1'b0;
    freeze     = 1'b0;
    flush      = 1'b0;
    ld_stall   = 1'b0;

    case (state_q)
      RUN: begin
        run_eval = 1'b1;
      end
      FLUSH: begin
        flush = 1'b1;
        if (dmem_busy) begin
          freeze = 1'b1;
        end else if (redirect_X) begin
          if (FLUSH_CYCLES == 1) begin
            state_d = RUN;
            fcnt_d  = 4'd0;
          end else begin
            fcnt_d = FC_RELOAD;
          end
        end else begin
          fcnt_d = fcnt_q - 4'd1;
          if (fcnt_q <= 4'd1) begin
            state_d = RUN;
            fcnt_d  = 4'd0;
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_busy) begin
          freeze     = 1'b1;
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        end else begin
          run_eval   = 1'b1;
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (run_eval) begin
      if (dmem_busy) begin
        freeze     = 1'b1;
        state_d    = MEM_WAIT;
        wait_cnt_d = 8'd1;
      end else if (redirect_X) begin
        // A coincident load-use is dropped: the ID instruction is being discarded anyway.
        flush = 1'b1;
        if (FLUSH_CYCLES == 1) begin
          state_d = RUN;
        end else begin
          state_d = FLUSH;
          fcnt_d  = FC_RELOAD;
        end
      end else if (ld_use) begin
        ld_stall = 1'b1;
      end
    end
  end

  // Outputs; reset forces the flush-only pattern immediately, independent of clk.
  always_comb begin
    stall_PC = ~rst & (freeze | ld_stall);
    stall_ID = ~rst & (freeze | ld_stall);
    stall_X  = ~rst & freeze;
    bubble_X = ~rst & ld_stall;
    flush_ID = rst | flush;
  end

  // Sticky timeout flag and wrapping perf counters; clr_cnt wins over a same-cycle increment.
  always_comb begin
    timeout_d   = timeout_q | (dmem_busy & (wait_cnt_d == MT_LIMIT));
    stall_cnt_d = clr_cnt ? 32'd0 : stall_cnt_q + {31'd0, stall_PC};
    flush_cnt_d = clr_cnt ? 32'd0 : flush_cnt_q + {31'd0, flush_ID};
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign timeout_err  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=3).
// Table-driven single-cycle decode vectors, then hand sequences for multi-cycle cases.
// Outputs are sampled mid-cycle, inputs driven 1 time unit after the rising edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_wen_X, ld_X, rs1_used_ID, rs2_used_ID, redirect_X, dmem_busy, clr_cnt;
  logic [4:0]  rd_X, rs1_ID, rs2_ID;
  logic        stall_PC, stall_ID, stall_X, bubble_X, flush_ID, timeout_err;
  logic [31:0] stall_cycles, flush_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst),
    .rf_wen_X(rf_wen_X), .ld_X(ld_X), .rd_X(rd_X),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .redirect_X(redirect_X), .dmem_busy(dmem_busy), .clr_cnt(clr_cnt),
    .stall_PC(stall_PC), .stall_ID(stall_ID), .stall_X(stall_X),
    .bubble_X(bubble_X), .flush_ID(flush_ID), .timeout_err(timeout_err),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  // expected output pattern: {stall_PC, stall_ID, stall_X, bubble_X, flush_ID}
  typedef struct {
    string      name;
    logic       rf_wen;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic       redir;
    logic       busy;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(string n, logic w, logic l, logic [4:0] d, logic [4:0] s1,
                              logic [4:0] s2, logic u1, logic u2, logic r, logic b,
                              logic [4:0] e);
    vec_t v;
    v.name = n; v.rf_wen = w; v.ld = l; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.rs1u = u1; v.rs2u = u2; v.redir = r; v.busy = b; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rf_wen_X = 0; ld_X = 0; rd_X = 0; rs1_ID = 0; rs2_ID = 0;
    rs1_used_ID = 0; rs2_used_ID = 0; redirect_X = 0; dmem_busy = 0; clr_cnt = 0;
  endtask

  task automatic drive_ld_use();
    rf_wen_X = 1; ld_X = 1; rd_X = 5'd5; rs2_ID = 5'd5; rs2_used_ID = 1;
    rs1_ID = 5'd1; rs1_used_ID = 1;
  endtask

  task automatic chk_out(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {stall_PC, stall_ID, stall_X, bubble_X, flush_ID};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: outputs {sPC,sID,sX,bub,flush} got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic clear_counters();
    idle_in();
    clr_cnt = 1;
    tick();
    clr_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk("lu_rs2",      1, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 5'b11010);
    vecs[1] = mk("lu_rd0",      1, 1, 5'd0, 5'd1, 5'd0, 1, 1, 0, 0, 5'b00000);
    vecs[2] = mk("lu_rs2unused",1, 1, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, 5'b00000);
    vecs[3] = mk("lu_notload",  1, 0, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 5'b00000);
    vecs[4] = mk("lu_nowen",    0, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 5'b00000);
    vecs[5] = mk("lu_rs1",      1, 1, 5'd9, 5'd9, 5'd2, 1, 0, 0, 0, 5'b11010);
    vecs[6] = mk("redir_lu",    1, 1, 5'd5, 5'd1, 5'd5, 1, 1, 1, 0, 5'b00001);
    vecs[7] = mk("busy_all",    1, 1, 5'd5, 5'd1, 5'd5, 1, 1, 1, 1, 5'b11100);
    vecs[8] = mk("idle",        0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'b00000);
    vecs[9] = mk("lu_rs1unused",1, 1, 5'd7, 5'd7, 5'd3, 0, 1, 0, 0, 5'b00000);

    // reset state, held before any clock edge
    idle_in();
    rst = 1;
    #3;
    chk_out("reset_outputs", 5'b00001);
    chk32("reset_timeout", {31'd0, timeout_err}, 32'd0);
    chk32("reset_stall_cnt", stall_cycles, 32'd0);
    chk32("reset_flush_cnt", flush_cycles, 32'd0);
    tick();
    rst = 0;
    tick();

    // single-cycle decode vectors from RUN; two idle cycles return the FSM to RUN
    for (int i = 0; i < 10; i++) begin
      rf_wen_X = vecs[i].rf_wen; ld_X = vecs[i].ld; rd_X = vecs[i].rd;
      rs1_ID = vecs[i].rs1; rs2_ID = vecs[i].rs2;
      rs1_used_ID = vecs[i].rs1u; rs2_used_ID = vecs[i].rs2u;
      redirect_X = vecs[i].redir; dmem_busy = vecs[i].busy;
      #4;
      chk_out(vecs[i].name, vecs[i].exp);
      tick();
      idle_in();
      tick();
      tick();
    end

    // load-use stall self-clears once the bubble reaches X
    clear_counters();
    drive_ld_use();
    #4;
    chk_out("seq1_stall", 5'b11010);
    tick();
    rf_wen_X = 0; ld_X = 0;
    #4;
    chk_out("seq1_after", 5'b00000);
    chk32("seq1_stall_cnt", stall_cycles, 32'd1);
    tick();

    // clr_cnt overrides a same-cycle increment
    drive_ld_use();
    clr_cnt = 1;
    tick();
    idle_in();
    #4;
    chk32("clr_override", stall_cycles, 32'd0);
    tick();

    // two-cycle flush on a single redirect pulse
    clear_counters();
    redirect_X = 1;
    #4;
    chk_out("seq3_flush0", 5'b00001);
    tick();
    redirect_X = 0;
    #4;
    chk_out("seq3_flush1", 5'b00001);
    tick();
    #4;
    chk_out("seq3_done", 5'b00000);
    chk32("seq3_flush_cnt", flush_cycles, 32'd2);
    tick();

    // freeze during FLUSH holds the flush count
    clear_counters();
    redirect_X = 1;
    tick();
    redirect_X = 0; dmem_busy = 1;
    #4;
    chk_out("flushbusy_frz", 5'b11101);
    tick();
    dmem_busy = 0;
    #4;
    chk_out("flushbusy_hold", 5'b00001);
    tick();
    #4;
    chk_out("flushbusy_done", 5'b00000);
    chk32("flushbusy_fcnt", flush_cycles, 32'd3);
    chk32("flushbusy_scnt", stall_cycles, 32'd1);
    tick();

    // memory wait outranks redirect, which then acts on the release cycle
    clear_counters();
    for (int k = 0; k < 4; k++) begin
      dmem_busy = 1; redirect_X = 1;
      #4;
      chk_out($sformatf("seq5_frz%0d", k), 5'b11100);
      tick();
    end
    dmem_busy = 0;
    #4;
    chk_out("seq5_release", 5'b00001);
    chk32("seq5_stall_cnt", stall_cycles, 32'd4);
    tick();
    idle_in();
    tick();
    tick();

    // timeout after the 3rd busy cycle, sticky, cleared only by async reset
    rst = 1;
    #4;
    chk32("seq6_rst_timeout", {31'd0, timeout_err}, 32'd0);
    tick();
    rst = 0;
    dmem_busy = 1;
    for (int k = 1; k <= 5; k++) begin
      #4;
      chk32($sformatf("seq6_timeout_c%0d", k), {31'd0, timeout_err}, {31'd0, (k >= 4)});
      tick();
    end
    #1;
    chk32("seq6_sticky", {31'd0, timeout_err}, 32'd1);
    chk_out("seq6_frz", 5'b11100);
    #1;
    rst = 1;
    #1;
    chk_out("seq6_async_rst", 5'b00001);
    chk32("seq6_async_timeout", {31'd0, timeout_err}, 32'd0);
    chk32("seq6_async_scnt", stall_cycles, 32'd0);
    chk32("seq6_async_fcnt", flush_cycles, 32'd0);
    tick();
    rst = 0;
    dmem_busy = 0;
    tick();
    #4;
    chk_out("seq6_after", 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
